// File: rtl/fetch_queue.sv
// Instruction prefetch queue: one outstanding imem request, a small {pc, instr} FIFO,
// and a valid/ready hand-off to decode with redirect flush.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_4,
  output logic [31:0] out_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = AW + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} st_e;

  st_e           st_q, st_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic [RW-1:0] reserved;
  logic          issue;
  logic          req_fire;
  logic          push;
  logic          pop;

  // A slot is reserved for the in-flight request so a returning word always fits.
  always_comb begin
    reserved = RW'(count_q) + RW'(st_q != ST_IDLE);
    issue    = ((st_q == ST_IDLE) || imem_resp_valid) && (reserved < RW'(DEPTH)) && !redirect_valid;
  end

  assign imem_req_valid = issue && reset_n;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign out_valid      = (count_q != '0);
  assign pop            = out_valid && out_ready;
  assign push           = imem_resp_valid && (st_q == ST_WAIT) && !redirect_valid;

  assign out_pc        = pc_mem_q[rd_ptr_q];
  assign out_pc_plus_4 = out_pc + 32'd4;
  assign out_instr     = instr_mem_q[rd_ptr_q];

  always_comb begin
    st_d       = st_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (redirect_valid) begin
      // Flush; an in-flight request becomes a drop unless its response is arriving now.
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      if (st_q != ST_IDLE) st_d = imem_resp_valid ? ST_IDLE : ST_DROP;
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
      st_d       = ST_WAIT;
    end else if (imem_resp_valid && (st_q != ST_IDLE)) begin
      st_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q       <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      st_q       <= st_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset; it is only read while count_q is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized bench for fetch_queue with an in-order variable-latency imem model.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_pc_plus_4   (out_pc_plus_4),
    .out_instr       (out_instr),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pend_q[$];
  int    cyc      = 0;
  int    n_req    = 0;
  int    base_req = 0;
  int    mem_lat  = 1;
  int    n_pass   = 0;
  int    n_chk    = 0;

  function automatic logic [31:0] wfn(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5A5A_5A5A;
  endfunction

  // Memory model: record accepted requests at the clock edge (mem_lat 0 = random 1..4).
  always @(posedge clk) begin
    pend_t p;
    if (!reset_n) begin
      pend_q.delete();
    end else begin
      if (imem_resp_valid && pend_q.size() > 0) void'(pend_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        p.addr = imem_req_addr;
        p.due  = cyc + ((mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat);
        pend_q.push_back(p);
        n_req++;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (reset_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = wfn(pend_q[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input int lat, input logic ordy);
    @(negedge clk);
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    out_ready      = ordy;
    mem_lat        = lat;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    base_req = n_req;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    popped;
    int    cycles;
    logic [31:0] exp_pc;

    reset_n        = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    tick(); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);

    // Sequential fetch, L=1
    do_reset(1, 1'b1); #1;
    chk("t1_req0_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_req0_addr", imem_req_addr, 32'h0);
    chk("t1_ov0", 32'(out_valid), 32'd0);
    tick(); #1;
    chk("t1_req1_addr", imem_req_addr, 32'h4);
    chk("t1_ov1", 32'(out_valid), 32'd0);
    tick(); #1;
    chk("t1_ov2", 32'(out_valid), 32'd1);
    chk("t1_pc0", out_pc, 32'h0);
    chk("t1_pc4_0", out_pc_plus_4, 32'h4);
    chk("t1_instr0", out_instr, wfn(32'h0));
    chk("t1_req2_addr", imem_req_addr, 32'h8);
    tick(); #1;
    chk("t1_pc1", out_pc, 32'h4);
    tick(); #1;
    chk("t1_pc2", out_pc, 32'h8);
    chk("t1_instr2", out_instr, wfn(32'h8));

    // Backpressure fill to DEPTH, then one pop frees one request
    do_reset(1, 1'b0); #1;
    chk("t2_req0_addr", imem_req_addr, 32'h0);
    repeat (4) tick();
    #1;
    chk("t2_full_req_a", 32'(imem_req_valid), 32'd0);
    tick(); #1;
    chk("t2_full_req_b", 32'(imem_req_valid), 32'd0);
    chk("t2_full_ov", 32'(out_valid), 32'd1);
    chk("t2_full_pc", out_pc, 32'h0);
    chk("t2_nreq4", 32'(n_req - base_req), 32'd4);
    tick(); out_ready = 1'b1; #1;
    chk("t2_pop_pc", out_pc, 32'h0);
    chk("t2_pop_req", 32'(imem_req_valid), 32'd0);
    tick(); out_ready = 1'b0; #1;
    chk("t2_refill_valid", 32'(imem_req_valid), 32'd1);
    chk("t2_refill_addr", imem_req_addr, 32'h10);
    chk("t2_head_pc", out_pc, 32'h4);
    tick(); tick(); #1;
    chk("t2_refull_req", 32'(imem_req_valid), 32'd0);
    chk("t2_nreq5", 32'(n_req - base_req), 32'd5);

    // L=3, redirect while 0x8 is outstanding
    do_reset(3, 1'b1); #1;
    chk("t3_req0_addr", imem_req_addr, 32'h0);
    repeat (3) tick();
    #1;
    chk("t3_req1_addr", imem_req_addr, 32'h4);
    repeat (3) tick();
    #1;
    chk("t3_req2_addr", imem_req_addr, 32'h8);
    tick(); #1;
    chk("t3_pc1", out_pc, 32'h4);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk("t3_redir_req", 32'(imem_req_valid), 32'd0);
    chk("t3_redir_ov", 32'(out_valid), 32'd0);
    tick(); redirect_valid = 1'b0; #1;
    chk("t3_drop_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t3_drop_req_addr", imem_req_addr, 32'h100);
    chk("t3_drop_ov", 32'(out_valid), 32'd0);
    tick(); #1;
    chk("t3_dropped_ov", 32'(out_valid), 32'd0);
    repeat (3) tick();
    #1;
    chk("t3_new_ov", 32'(out_valid), 32'd1);
    chk("t3_new_pc", out_pc, 32'h100);
    chk("t3_new_instr", out_instr, wfn(32'h100));

    // Redirect coinciding with a pop and a returning response
    do_reset(1, 1'b1);
    tick(); tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h203; #1;
    chk("t4_pop_pc", out_pc, 32'h4);
    chk("t4_pop_ov", 32'(out_valid), 32'd1);
    chk("t4_redir_req", 32'(imem_req_valid), 32'd0);
    tick(); redirect_valid = 1'b0; #1;
    chk("t4_flushed_ov", 32'(out_valid), 32'd0);
    chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_req_addr", imem_req_addr, 32'h200);
    tick(); tick(); #1;
    chk("t4_new_pc", out_pc, 32'h200);
    chk("t4_new_instr", out_instr, wfn(32'h200));

    // Wrap at the top of the address space
    do_reset(1, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    chk("t6_redir_req", 32'(imem_req_valid), 32'd0);
    tick(); redirect_valid = 1'b0; #1;
    chk("t6_req_top", imem_req_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("t6_req_wrap", imem_req_addr, 32'h0);
    tick(); #1;
    chk("t6_pc_top", out_pc, 32'hFFFF_FFFC);
    chk("t6_pc4_top", out_pc_plus_4, 32'h0);
    chk("t6_instr_top", out_instr, wfn(32'hFFFF_FFFC));
    tick(); #1;
    chk("t6_pc_wrap", out_pc, 32'h0);
    chk("t6_pc4_wrap", out_pc_plus_4, 32'h4);

    // Asynchronous reset mid-burst
    do_reset(1, 1'b1);
    repeat (3) tick();
    #1;
    chk("t7_pre_ov", 32'(out_valid), 32'd1);
    chk("t7_pre_req", 32'(imem_req_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("t7_async_ov", 32'(out_valid), 32'd0);
    chk("t7_async_req", 32'(imem_req_valid), 32'd0);

    // Random ready and latency, 1000 instructions in order
    do_reset(0, 1'b1);
    exp_pc = 32'h0;
    popped = 0;
    cycles = 0;
    while (popped < 1000 && cycles < 20000) begin
      tick();
      imem_req_ready = 1'($urandom_range(1, 0));
      out_ready      = ($urandom_range(3, 0) != 0);
      #1;
      if (out_valid && out_ready) begin
        chk("rnd_pc", out_pc, exp_pc);
        chk("rnd_pc4", out_pc_plus_4, exp_pc + 32'd4);
        chk("rnd_instr", out_instr, wfn(exp_pc));
        exp_pc = exp_pc + 32'd4;
        popped++;
      end
      cycles++;
    end
    chk("rnd_count", 32'(popped), 32'd1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
